// File: rtl/irq_pkg.sv
// Shared encodings and constants for the peripheral interrupt controller.
package irq_pkg;

  localparam int          IRQ_MAX         = 16;
  localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  // Interrupt bit set, low five bits hold 16 + line index.
  function automatic logic [31:0] mcause_for(input logic [3:0] id);
    return MCAUSE_IRQ_BASE + {28'd0, id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic [3:0]       id,
  output logic             valid
);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Scan from the top down so the last hit, the lowest index, wins.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Presents masked level interrupts to the core one at a time and returns
// a one-cycle acknowledge pulse to the serviced peripheral on completion.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_done_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_rst_o
);

  state_t             state;
  state_t             state_next;
  logic [3:0]         id;
  logic [3:0]         pend_id;
  logic               pend_valid;
  logic [N_IRQ-1:0]   pending;

  assign pending = irq_i & mie_i;

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .req   (pending),
    .id    (pend_id),
    .valid (pend_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      id       <= '0;
      mcause_o <= '0;
    end else begin
      state <= state_next;
      // id and mcause only move on a new latch; mcause stays after completion.
      if (state == S_IDLE && pend_valid) begin
        id       <= pend_id;
        mcause_o <= mcause_for(pend_id);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (pend_valid) state_next = S_ACTIVE;
      // Line changes are ignored once latched; only completion moves on.
      S_ACTIVE: if (int_done_i) state_next = S_ACK;
      S_ACK:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    int_o     = (state == S_ACTIVE);
    irq_rst_o = '0;
    if (state == S_ACK) irq_rst_o = N_IRQ'(1) << id;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a simple peripheral model that
// drops its request on the edge that ends its acknowledge pulse.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_i;
  logic [7:0]  mie_i;
  logic        int_done_i;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [7:0]  irq_rst_o;

  int checks   = 0;
  int failures = 0;

  irq_controller #(.N_IRQ(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (irq_i),
    .mie_i      (mie_i),
    .int_done_i (int_done_i),
    .int_o      (int_o),
    .mcause_o   (mcause_o),
    .irq_rst_o  (irq_rst_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs and checks sit 1 time unit after the edge.
  // Peripherals clear their request on the edge where their ack pulse is seen.
  task automatic step();
    logic [7:0] ack_seen;
    ack_seen = irq_rst_o;
    @(posedge clk);
    #1;
    irq_i = irq_i & ~ack_seen;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_i = '0; mie_i = '0; int_done_i = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({int_o, mcause_o, irq_rst_o} !== 41'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got int=%b mcause=%h rst=%h want all zero", i, int_o, mcause_o, irq_rst_o);
      end
    end
  endtask

  task automatic test_single();
    mie_i = 8'hFF;
    irq_i = 8'h08;
    step();
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL single_int got %b want 1", int_o); end
    checks++; if (mcause_o !== 32'h8000_0013) begin failures++; $display("FAIL single_mcause got %h want 80000013", mcause_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (int_o !== 1'b1 || irq_rst_o !== 8'h00) begin
        failures++; $display("FAIL single_hold cyc=%0d got int=%b rst=%h want 1/00", i, int_o, irq_rst_o);
      end
    end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL single_done_int got %b want 0", int_o); end
    checks++; if (irq_rst_o !== 8'h08) begin failures++; $display("FAIL single_ack got %h want 08", irq_rst_o); end
    checks++; if (mcause_o !== 32'h8000_0013) begin failures++; $display("FAIL single_mcause_kept got %h want 80000013", mcause_o); end
    step();
    checks++; if (irq_rst_o !== 8'h00) begin failures++; $display("FAIL single_ack_width got %h want 00", irq_rst_o); end
    step();
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL single_no_retrig got %b want 0", int_o); end
  endtask

  task automatic test_back_to_back();
    irq_i = 8'b0010_0100;
    step();
    checks++; if (mcause_o !== 32'h8000_0012 || int_o !== 1'b1) begin
      failures++; $display("FAIL b2b_first got int=%b mcause=%h want 1/80000012", int_o, mcause_o); end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h04) begin failures++; $display("FAIL b2b_ack1 got %h want 04", irq_rst_o); end
    step();
    checks++; if (int_o !== 1'b0 || irq_rst_o !== 8'h00) begin
      failures++; $display("FAIL b2b_gap got int=%b rst=%h want 0/00", int_o, irq_rst_o); end
    step();
    checks++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_0015) begin
      failures++; $display("FAIL b2b_second got int=%b mcause=%h want 1/80000015", int_o, mcause_o); end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h20) begin failures++; $display("FAIL b2b_ack2 got %h want 20", irq_rst_o); end
    step(); step();
    checks++; if (int_o !== 1'b0 || irq_i !== 8'h00) begin
      failures++; $display("FAIL b2b_drained got int=%b irq=%h want 0/00", int_o, irq_i); end
  endtask

  task automatic test_mask();
    mie_i = 8'hFB;
    irq_i = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL mask_blocked cyc=%0d got %b want 0", i, int_o); end
    end
    mie_i = 8'hFF;
    step();
    checks++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_0012) begin
      failures++; $display("FAIL mask_enable got int=%b mcause=%h want 1/80000012", int_o, mcause_o); end
    mie_i = 8'hFB;
    step(); step();
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL mask_late_clear got %b want 1", int_o); end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h04 || int_o !== 1'b0) begin
      failures++; $display("FAIL mask_ack got rst=%h int=%b want 04/0", irq_rst_o, int_o); end
    step();
    mie_i = 8'hFF;
  endtask

  task automatic test_reset_mid();
    irq_i = 8'h01;
    step();
    checks++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_0010) begin
      failures++; $display("FAIL rmid_take got int=%b mcause=%h want 1/80000010", int_o, mcause_o); end
    reset = 1'b1;
    step();
    checks++; if ({int_o, mcause_o, irq_rst_o} !== 41'd0) begin
      failures++; $display("FAIL rmid_zero got int=%b mcause=%h rst=%h want all zero", int_o, mcause_o, irq_rst_o); end
    step();
    checks++; if (irq_rst_o !== 8'h00 || irq_i !== 8'h01) begin
      failures++; $display("FAIL rmid_no_ack got rst=%h irq=%h want 00/01", irq_rst_o, irq_i); end
    reset = 1'b0;
    step();
    checks++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_0010) begin
      failures++; $display("FAIL rmid_retake got int=%b mcause=%h want 1/80000010", int_o, mcause_o); end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h01) begin failures++; $display("FAIL rmid_ack got %h want 01", irq_rst_o); end
    step();
  endtask

  task automatic test_done_idle_keyboard();
    irq_i = 8'h00;
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h00 || int_o !== 1'b0) begin
      failures++; $display("FAIL idle_done got rst=%h int=%b want 00/0", irq_rst_o, int_o); end
    // Still in IDLE: a new request must be taken on the very next edge.
    irq_i = 8'h02;
    step();
    checks++; if (int_o !== 1'b1 || mcause_o !== 32'h8000_0011) begin
      failures++; $display("FAIL kbd_take got int=%b mcause=%h want 1/80000011", int_o, mcause_o); end
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    checks++; if (irq_rst_o !== 8'h02) begin failures++; $display("FAIL kbd_ack got %h want 02", irq_rst_o); end
    step();
    checks++; if (irq_i !== 8'h00) begin failures++; $display("FAIL kbd_cleared got %h want 00", irq_i); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (int_o !== 1'b0 || irq_rst_o !== 8'h00) begin
        failures++; $display("FAIL kbd_no_retrig cyc=%0d got int=%b rst=%h want 0/00", i, int_o, irq_rst_o); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_reset_mid();
    test_done_idle_keyboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
